ifu_fetch: RTL and testbench

IFU_FETCH -- requirements
Module: ifu_fetch

---
 rtl/ifu_fetch_pkg.sv | 21 ++
 rtl/ifu_fetch.sv | 130 +++++++++++++
 tb/tb_ifu_fetch.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ifu_fetch_pkg.sv
// Shared definitions for the instruction fetch unit.
//   ifu_state_e  : fetch FSM states
//   INST_W       : instruction word width
//   INST_BYTES / MEM_BYTES and the matching offset-bit counts used for
//   alignment checks and doubleword address formation.
package ifu_fetch_pkg;

  localparam int INST_W         = 32;
  localparam int INST_BYTES     = 4;
  localparam int MEM_BYTES      = 8;
  localparam int INST_OFFS_BITS = $clog2(INST_BYTES);  // 2
  localparam int MEM_OFFS_BITS  = $clog2(MEM_BYTES);   // 3

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,  // capture pc_i
    ST_REQ  = 2'd1,  // memory read outstanding
    ST_HOLD = 2'd2,  // instruction presented to decode
    ST_DROP = 2'd3   // redirected while a read was outstanding; absorb its ack
  } ifu_state_e;

endpackage

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: one instruction in flight at a time.
// The PC register lives outside; it advances on pc_step and is loaded with
// a jump target on redirect.
//
// Ports
//   clk, rst        : clock, async active-high reset
//   pc_i            : current fetch address
//   pc_step         : advance PC (combinational, only on decode handshake)
//   redirect        : PC was loaded with a jump target; flush fetch in flight
//   mem_req/addr    : doubleword read request, held until mem_ack
//   mem_ack/rdata   : read response
//   inst_valid/ready, inst, inst_pc, inst_fault : decode interface
//   fetch_cnt       : number of instructions accepted by decode
module ifu_fetch
  import ifu_fetch_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [XLEN-1:0]     pc_i,
  output logic                pc_step,
  input  logic                redirect,
  output logic                mem_req,
  output logic [XLEN-1:0]     mem_addr,
  input  logic                mem_ack,
  input  logic [63:0]         mem_rdata,
  output logic                inst_valid,
  input  logic                inst_ready,
  output logic [INST_W-1:0]   inst,
  output logic [XLEN-1:0]     inst_pc,
  output logic                inst_fault,
  output logic [63:0]         fetch_cnt
);

  ifu_state_e          state_q, state_d;
  logic [XLEN-1:0]     pc_q, pc_d;
  logic [XLEN-1:0]     addr_q, addr_d;
  logic [INST_W-1:0]   inst_q, inst_d;
  logic                fault_q, fault_d;
  logic [63:0]         cnt_q, cnt_d;

  logic                misaligned;
  logic                fire;
  logic [INST_W-1:0]   sel_word;

  assign misaligned = |pc_i[INST_OFFS_BITS-1:0];
  // pc_q[2] picks the upper or lower half of the doubleword.
  assign sel_word   = pc_q[INST_OFFS_BITS] ? mem_rdata[63:32] : mem_rdata[31:0];
  assign fire       = (state_q == ST_HOLD) & inst_ready & ~redirect;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    inst_d  = inst_q;
    fault_d = fault_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (!redirect) begin
          pc_d   = pc_i;
          addr_d = {pc_i[XLEN-1:MEM_OFFS_BITS], {MEM_OFFS_BITS{1'b0}}};
          if (misaligned) begin
            // Fault is reported straight away; memory is never touched.
            inst_d  = '0;
            fault_d = 1'b1;
            state_d = ST_HOLD;
          end else begin
            state_d = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        if (mem_ack) begin
          if (redirect) begin
            state_d = ST_IDLE;  // data arrives too late to be useful
          end else begin
            inst_d  = sel_word;
            fault_d = 1'b0;
            state_d = ST_HOLD;
          end
        end else if (redirect) begin
          state_d = ST_DROP;
        end
      end
      ST_HOLD: begin
        if (fire) begin
          cnt_d   = cnt_q + 64'd1;
          state_d = ST_IDLE;
        end else if (redirect) begin
          state_d = ST_IDLE;
        end
      end
      ST_DROP: begin
        // The read must still complete; redirect has nothing more to flush.
        if (mem_ack) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      addr_q  <= '0;
      inst_q  <= '0;
      fault_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      inst_q  <= inst_d;
      fault_q <= fault_d;
      cnt_q   <= cnt_d;
    end
  end

  assign pc_step    = fire;
  assign mem_req    = (state_q == ST_REQ) | (state_q == ST_DROP);
  assign mem_addr   = addr_q;
  assign inst_valid = (state_q == ST_HOLD);
  assign inst       = inst_q;
  assign inst_pc    = pc_q;
  assign inst_fault = fault_q;
  assign fetch_cnt  = cnt_q;

endmodule

// File: tb/tb_ifu_fetch.sv
module tb_ifu_fetch;

  localparam int XLEN = 64;
  localparam logic [63:0] RDATA = 64'h00100093_00000413;

  logic              clk = 1'b0;
  logic              rst;
  logic [XLEN-1:0]   pc_i;
  logic              pc_step;
  logic              redirect;
  logic              mem_req;
  logic [XLEN-1:0]   mem_addr;
  logic              mem_ack;
  logic [63:0]       mem_rdata;
  logic              inst_valid;
  logic              inst_ready;
  logic [31:0]       inst;
  logic [XLEN-1:0]   inst_pc;
  logic              inst_fault;
  logic [63:0]       fetch_cnt;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_cnt = 64'd0;

  ifu_fetch #(.XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .pc_i(pc_i), .pc_step(pc_step), .redirect(redirect),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc),
    .inst_fault(inst_fault), .fetch_cnt(fetch_cnt)
  );

  always #5 clk = ~clk;

  // Advance one edge and settle 1ns past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; pc_i = 64'h8000_0000; redirect = 0; mem_ack = 0;
    mem_rdata = RDATA; inst_ready = 0;
    #1;
    checks++;
    if ({mem_req, inst_valid, pc_step, inst_fault} !== 4'b0 || inst !== 32'h0 ||
        inst_pc !== 64'h0 || mem_addr !== 64'h0 || fetch_cnt !== 64'h0) begin
      errors++;
      $display("FAIL reset_outputs: req=%b vld=%b step=%b flt=%b inst=%h pc=%h addr=%h cnt=%0d, want all zero",
               mem_req, inst_valid, pc_step, inst_fault, inst, inst_pc, mem_addr, fetch_cnt);
    end
    tick(); tick();
    rst = 1'b0;
    // e1: capture, request issued
    tick();
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 64'h8000_0000 || inst_valid !== 1'b0) begin
      errors++;
      $display("FAIL first_req: req=%b addr=%h vld=%b, want 1 80000000 0", mem_req, mem_addr, inst_valid);
    end
    tick(); tick();        // e2, e3: ack not yet
    mem_ack = 1'b1;
    tick();                // e4: ack sampled
    mem_ack = 1'b0;
    checks++;
    if (inst_valid !== 1'b1 || inst !== 32'h0000_0413 || inst_pc !== 64'h8000_0000 ||
        inst_fault !== 1'b0 || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL first_inst: vld=%b inst=%h pc=%h flt=%b req=%b, want 1 00000413 80000000 0 0",
               inst_valid, inst, inst_pc, inst_fault, mem_req);
    end
    inst_ready = 1'b1;
    #1;
    checks++;
    if (pc_step !== 1'b1) begin
      errors++;
      $display("FAIL first_step: pc_step=%b want 1", pc_step);
    end
    tick();
    inst_ready = 1'b0;
    exp_cnt++;
    checks++;
    if (fetch_cnt !== exp_cnt || inst_valid !== 1'b0) begin
      errors++;
      $display("FAIL first_count: cnt=%0d vld=%b want %0d 0", fetch_cnt, inst_valid, exp_cnt);
    end
  endtask

  task automatic test_stall();
    pc_i = 64'h8000_0004;
    tick();                // capture -> REQ
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 64'h8000_0000) begin
      errors++;
      $display("FAIL stall_addr: req=%b addr=%h want 1 80000000", mem_req, mem_addr);
    end
    tick(); tick();
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (inst_valid !== 1'b1 || inst !== 32'h0010_0093 || inst_pc !== 64'h8000_0004 || pc_step !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold[%0d]: vld=%b inst=%h pc=%h step=%b want 1 00100093 80000004 0",
                 i, inst_valid, inst, inst_pc, pc_step);
      end
      tick();
    end
    inst_ready = 1'b1;
    #1;
    checks++;
    if (pc_step !== 1'b1) begin
      errors++;
      $display("FAIL stall_step: pc_step=%b want 1", pc_step);
    end
    pc_i = 64'h8000_0008;
    tick();
    exp_cnt++;
    checks++;
    if (pc_step !== 1'b0 || fetch_cnt !== exp_cnt) begin
      errors++;
      $display("FAIL stall_after: step=%b cnt=%0d want 0 %0d", pc_step, fetch_cnt, exp_cnt);
    end
    inst_ready = 1'b0;
  endtask

  task automatic test_redirect();
    // redirect during REQ -> DROP
    tick();                // capture 0x80000008 -> REQ
    redirect = 1'b1; pc_i = 64'h8000_1000;
    tick();
    redirect = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (mem_req !== 1'b1 || mem_addr !== 64'h8000_0008 || inst_valid !== 1'b0 || pc_step !== 1'b0) begin
        errors++;
        $display("FAIL drop_hold[%0d]: req=%b addr=%h vld=%b step=%b want 1 80000008 0 0",
                 i, mem_req, mem_addr, inst_valid, pc_step);
      end
      tick();
    end
    // redirect in DROP is ignored
    redirect = 1'b1;
    #1;
    checks++;
    if (mem_req !== 1'b1 || pc_step !== 1'b0) begin
      errors++;
      $display("FAIL drop_redirect: req=%b step=%b want 1 0", mem_req, pc_step);
    end
    tick();
    redirect = 1'b0;
    mem_ack = 1'b1;
    tick();                // ack absorbed -> IDLE
    mem_ack = 1'b0;
    checks++;
    if (mem_req !== 1'b0 || inst_valid !== 1'b0) begin
      errors++;
      $display("FAIL drop_done: req=%b vld=%b want 0 0", mem_req, inst_valid);
    end
    tick();                // capture new target
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 64'h8000_1000) begin
      errors++;
      $display("FAIL redirect_target: req=%b addr=%h want 1 80001000", mem_req, mem_addr);
    end
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    checks++;
    if (inst_valid !== 1'b1 || inst !== 32'h0000_0413 || inst_pc !== 64'h8000_1000) begin
      errors++;
      $display("FAIL redirect_inst: vld=%b inst=%h pc=%h want 1 00000413 80001000", inst_valid, inst, inst_pc);
    end
    // redirect together with ready in HOLD
    redirect = 1'b1; inst_ready = 1'b1;
    #1;
    checks++;
    if (pc_step !== 1'b0) begin
      errors++;
      $display("FAIL hold_redirect_step: pc_step=%b want 0", pc_step);
    end
    tick();
    checks++;
    if (inst_valid !== 1'b0 || fetch_cnt !== exp_cnt || pc_step !== 1'b0) begin
      errors++;
      $display("FAIL hold_redirect: vld=%b cnt=%0d step=%b want 0 %0d 0", inst_valid, fetch_cnt, pc_step, exp_cnt);
    end
    // redirect held in IDLE: no capture
    pc_i = 64'h8000_0010;
    tick();
    checks++;
    if (mem_req !== 1'b0 || inst_pc !== 64'h8000_1000) begin
      errors++;
      $display("FAIL idle_redirect: req=%b pc=%h want 0 80001000", mem_req, inst_pc);
    end
    redirect = 1'b0; inst_ready = 1'b0;
    // redirect and ack in the same REQ cycle -> straight to IDLE
    tick();
    redirect = 1'b1; mem_ack = 1'b1;
    tick();
    redirect = 1'b0; mem_ack = 1'b0;
    checks++;
    if (mem_req !== 1'b0 || inst_valid !== 1'b0) begin
      errors++;
      $display("FAIL req_redirect_ack: req=%b vld=%b want 0 0", mem_req, inst_valid);
    end
  endtask

  task automatic test_fault();
    pc_i = 64'h8000_0002;
    tick();
    checks++;
    if (mem_req !== 1'b0 || inst_valid !== 1'b1 || inst_fault !== 1'b1 ||
        inst !== 32'h0 || inst_pc !== 64'h8000_0002) begin
      errors++;
      $display("FAIL fault: req=%b vld=%b flt=%b inst=%h pc=%h want 0 1 1 00000000 80000002",
               mem_req, inst_valid, inst_fault, inst, inst_pc);
    end
    inst_ready = 1'b1;
    pc_i = 64'h8000_0100;
    tick();
    inst_ready = 1'b0;
    exp_cnt++;
    checks++;
    if (fetch_cnt !== exp_cnt || inst_valid !== 1'b0) begin
      errors++;
      $display("FAIL fault_accept: cnt=%0d vld=%b want %0d 0", fetch_cnt, inst_valid, exp_cnt);
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] pcs [2];
    logic [31:0] want [2];
    pcs[0] = 64'h8000_0100; pcs[1] = 64'h8000_0104;
    want[0] = 32'h0000_0413; want[1] = 32'h0010_0093;
    for (int k = 0; k < 2; k++) begin
      pc_i = pcs[k];
      tick();              // capture
      mem_ack = 1'b1;
      tick();              // zero-wait ack
      mem_ack = 1'b0;
      checks++;
      if (inst_valid !== 1'b1 || inst !== want[k] || inst_pc !== pcs[k] || inst_fault !== 1'b0) begin
        errors++;
        $display("FAIL b2b[%0d]: vld=%b inst=%h pc=%h flt=%b want 1 %h %h 0",
                 k, inst_valid, inst, inst_pc, inst_fault, want[k], pcs[k]);
      end
      inst_ready = 1'b1;
      tick();              // fire
      inst_ready = 1'b0;
      exp_cnt++;
    end
    checks++;
    if (fetch_cnt !== exp_cnt) begin
      errors++;
      $display("FAIL b2b_count: cnt=%0d want %0d", fetch_cnt, exp_cnt);
    end
  endtask

  task automatic test_reset_mid();
    pc_i = 64'h8000_0200;
    tick();                // REQ
    #2 rst = 1'b1;
    #1;
    exp_cnt = 64'd0;
    checks++;
    if (mem_req !== 1'b0 || mem_addr !== 64'h0 || inst_pc !== 64'h0 ||
        fetch_cnt !== 64'h0 || inst_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: req=%b addr=%h pc=%h cnt=%0d vld=%b want all zero",
               mem_req, mem_addr, inst_pc, fetch_cnt, inst_valid);
    end
    tick();
    rst = 1'b0;
    pc_i = 64'h8000_0300;
    mem_ack = 1'b1;        // stray ack with mem_req=0
    tick();
    mem_ack = 1'b0;
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 64'h8000_0300 || inst_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_stray_ack: req=%b addr=%h vld=%b want 1 80000300 0", mem_req, mem_addr, inst_valid);
    end
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    checks++;
    if (inst_valid !== 1'b1 || inst !== 32'h0000_0413 || inst_pc !== 64'h8000_0300) begin
      errors++;
      $display("FAIL reset_refetch: vld=%b inst=%h pc=%h want 1 00000413 80000300", inst_valid, inst, inst_pc);
    end
  endtask

  initial begin
    test_reset();
    test_stall();
    test_redirect();
    test_fault();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
